commit_ctrl: RTL and testbench
==============================

COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 Parameter FLUSH_HOLD, default 2, number of cycles commit stays blocked after a branch-override redirect (legal range 1..15).
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 rob_valid/rob_ready/rob_load/rob_store/rob_lsmiss/rob_bco_valid/rob_bco_taken  in  1 each  ROB head entry flags.
REQ-005 rob_pc/rob_value/rob_bco_target  in  32 each; rob_idx in 4; rob_dst in 5; rob_fid in 8; rob_lswidth/rob_bco_pattern in 2; rob_cmtdelay in 4.
REQ-006 rob_en_commit  out  1  pops ROB head; combinational.
REQ-007 rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32; rf_wrob  out  4: architectural register write and rename release.
REQ-008 sb_cmt_req  out  1; sb_cmt_fid  out  8: store-buffer commit request; sb_cmt_ack  in  1.
REQ-009 lsr_req  out  1; lsr_addr  out  32; lsr_width  out  2: load-miss replay request; lsr_done  in  1; lsr_data  in  32.
REQ-010 bco_valid  out  1; bco_target  out  32; bco_pc  out  32; bco_pattern  out  2; bco_taken  out  1: redirect/flush broadcast to fetch, ROB and predictor.

Function
REQ-011 FSM states RUN, STORE_WAIT, MISS_WAIT, FLUSH; encoding from the shared package.
REQ-012 Head is retirable in RUN when rob_valid & rob_ready & rob_cmtdelay==0; otherwise no output changes and rob_en_commit=0.
REQ-013 RUN, retirable, plain op (no store, no lsmiss, no bco): rob_en_commit=1 same cycle; stay RUN; throughput one commit per cycle.
REQ-014 rf_wen/rf_waddr/rf_wdata/rf_wrob are registered: asserted exactly one cycle after the committing cycle, with rf_wen=0 when dst==0 or the op is a store.
REQ-015 RUN, retirable store: rob_en_commit=0; next cycle sb_cmt_req=1 with sb_cmt_fid=rob_fid; enter STORE_WAIT.
REQ-016 STORE_WAIT: sb_cmt_req held high until sb_cmt_ack; in the ack cycle rob_en_commit=1, next cycle sb_cmt_req=0 and state RUN.
REQ-017 RUN, retirable load with rob_lsmiss: rob_en_commit=0; next cycle one-cycle lsr_req pulse with lsr_addr=rob_value, lsr_width=rob_lswidth; enter MISS_WAIT.
REQ-018 MISS_WAIT: on lsr_done rob_en_commit=1; rf write (per REQ-014) carries lsr_data; return RUN. lsr_done outside MISS_WAIT is ignored.
REQ-019 RUN, retirable with rob_bco_valid: rob_en_commit=1; next cycle one-cycle bco_valid pulse with head pc/target/pattern/taken; enter FLUSH.
REQ-020 FLUSH: rob_en_commit forced 0 for FLUSH_HOLD cycles counted from the bco_valid cycle, then RUN; rob_valid ignored while in FLUSH.
REQ-021 A branch-override head that also writes a register performs the rf write in the same cycle as bco_valid.
REQ-022 Flush counter is 4 bits, saturating at zero; no wrap.
REQ-023 rob_en_commit never asserts when rob_valid=0.

Reset
REQ-024 On resetn=0: state RUN; rob_en_commit, rf_wen, sb_cmt_req, lsr_req, bco_valid = 0; flush counter 0; data outputs 0.
REQ-025 Reset in STORE_WAIT, MISS_WAIT or FLUSH abandons the operation; no commit, write or request is issued for it.

Configuration
REQ-026 Macro COMMIT_PERF_COUNTERS_EN: when defined, adds outputs perf_commit_cnt (32) and perf_redirect_cnt (32), counting rob_en_commit cycles and bco_valid pulses, wrapping modulo 2^32, cleared by reset.
REQ-027 Without COMMIT_PERF_COUNTERS_EN the ports and counters do not exist; all other behaviour is identical.

Structure
REQ-028 Shared package holds FSM state encoding, lswidth encodings (byte/half/word) and the REG_ZERO constant (5'd0).
REQ-029 Counters of REQ-026 live in one sub-module commit_perf_counters, instantiated only under the macro.

Verification
REQ-030 Three consecutive ready plain ops, dst=3/0/7 -> rob_en_commit high 3 cycles; rf_wen next cycles 1/0/1 with rf_waddr 3, 7.
REQ-031 Store at head, sb_cmt_ack after 4 cycles -> sb_cmt_req high 4 cycles; rob_en_commit exactly in the ack cycle; no rf_wen.
REQ-032 Missed load, rob_value=0x1000_0040, lswidth=word, lsr_done after 6 cycles with data 0xDEADBEEF -> one lsr_req pulse, addr 0x1000_0040; rf_wdata=0xDEADBEEF one cycle after commit.
REQ-033 Branch-override head target 0x0000_2000, FLUSH_HOLD=2 -> commit, bco_valid pulse with target 0x2000, no commit for 2 cycles despite rob_valid=1.
REQ-034 Head with rob_cmtdelay=3, ready=1 -> no commit until cmtdelay==0; head with ready=0 -> permanent stall.
REQ-035 resetn low during MISS_WAIT, then lsr_done -> no commit, no rf_wen; state RUN.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg: shared FSM state encoding, load/store width codes and register constants.
package commit_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        MISS_WAIT  = 2'd2,
        FLUSH      = 2'd3
    } state_t;
    localparam logic [1:0] LSW_BYTE = 2'd0;
    localparam logic [1:0] LSW_HALF = 2'd1;
    localparam logic [1:0] LSW_WORD = 2'd2;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/commit_perf_counters.sv
// commit_perf_counters: free-running commit and redirect event counters, wrapping modulo 2^32.
module commit_perf_counters
    import commit_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        commit,
    input  logic        redirect,
    output logic [31:0] perf_commit_cnt,
    output logic [31:0] perf_redirect_cnt
);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_commit_cnt   <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            perf_commit_cnt   <= perf_commit_cnt + 32'(commit);
            perf_redirect_cnt <= perf_redirect_cnt + 32'(redirect);
        end
    end
endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl: ROB-head retirement FSM (store handshake, load-miss replay, branch-override flush).
// Optional perf counters via COMMIT_PERF_COUNTERS_EN.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rob_valid,
    input  logic        rob_ready,
    input  logic        rob_load,
    input  logic        rob_store,
    input  logic        rob_lsmiss,
    input  logic        rob_bco_valid,
    input  logic        rob_bco_taken,
    input  logic [31:0] rob_pc,
    input  logic [31:0] rob_value,
    input  logic [31:0] rob_bco_target,
    input  logic [3:0]  rob_idx,
    input  logic [4:0]  rob_dst,
    input  logic [7:0]  rob_fid,
    input  logic [1:0]  rob_lswidth,
    input  logic [1:0]  rob_bco_pattern,
    input  logic [3:0]  rob_cmtdelay,
    output logic        rob_en_commit,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [3:0]  rf_wrob,
    output logic        sb_cmt_req,
    output logic [7:0]  sb_cmt_fid,
    input  logic        sb_cmt_ack,
    output logic        lsr_req,
    output logic [31:0] lsr_addr,
    output logic [1:0]  lsr_width,
    input  logic        lsr_done,
    input  logic [31:0] lsr_data,
`ifdef COMMIT_PERF_COUNTERS_EN
    output logic [31:0] perf_commit_cnt,
    output logic [31:0] perf_redirect_cnt,
`endif
    output logic        bco_valid,
    output logic [31:0] bco_target,
    output logic [31:0] bco_pc,
    output logic [1:0]  bco_pattern,
    output logic        bco_taken
);
    localparam logic [3:0] HOLD = 4'(FLUSH_HOLD);

    state_t     state, state_n;
    logic [3:0] flush_cnt;
    logic       retire, is_miss, is_bco;

    // Priority when flags overlap: store, then missed load, then branch override.
    always_comb begin
        retire        = state == RUN && rob_valid && rob_ready && rob_cmtdelay == 4'd0;
        is_miss       = rob_load && rob_lsmiss && !rob_store;
        is_bco        = rob_bco_valid && !rob_store && !is_miss;
        rob_en_commit = rob_valid && (retire ? !(rob_store || is_miss) :
                        state == STORE_WAIT ? sb_cmt_ack :
                        state == MISS_WAIT && lsr_done);
        state_n       = state;
        case (state)
            RUN:        state_n = !retire ? RUN : rob_store ? STORE_WAIT :
                                  is_miss ? MISS_WAIT : is_bco ? FLUSH : RUN;
            STORE_WAIT: state_n = sb_cmt_ack ? RUN : STORE_WAIT;
            MISS_WAIT:  state_n = lsr_done ? RUN : MISS_WAIT;
            FLUSH:      state_n = flush_cnt <= 4'd1 ? RUN : FLUSH;
            default:    state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= RUN;
            flush_cnt   <= '0;
            rf_wen      <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rf_wrob     <= '0;
            sb_cmt_req  <= 1'b0;
            sb_cmt_fid  <= '0;
            lsr_req     <= 1'b0;
            lsr_addr    <= '0;
            lsr_width   <= '0;
            bco_valid   <= 1'b0;
            bco_target  <= '0;
            bco_pc      <= '0;
            bco_pattern <= '0;
            bco_taken   <= 1'b0;
        end else begin
            state      <= state_n;
            flush_cnt  <= retire && is_bco ? HOLD : flush_cnt == 4'd0 ? 4'd0 : flush_cnt - 4'd1;
            rf_wen     <= rob_en_commit && !rob_store && rob_dst != REG_ZERO;
            sb_cmt_req <= state_n == STORE_WAIT;
            lsr_req    <= retire && is_miss;
            bco_valid  <= retire && is_bco;
            if (rob_en_commit) begin
                rf_waddr <= rob_dst;
                rf_wdata <= state == MISS_WAIT ? lsr_data : rob_value;
                rf_wrob  <= rob_idx;
            end
            if (retire && rob_store)
                sb_cmt_fid <= rob_fid;
            if (retire && is_miss) begin
                lsr_addr  <= rob_value;
                lsr_width <= rob_lswidth;
            end
            if (retire && is_bco) begin
                bco_target  <= rob_bco_target;
                bco_pc      <= rob_pc;
                bco_pattern <= rob_bco_pattern;
                bco_taken   <= rob_bco_taken;
            end
        end
    end

`ifdef COMMIT_PERF_COUNTERS_EN
    commit_perf_counters u_perf (
        .clk               (clk),
        .resetn            (resetn),
        .commit            (rob_en_commit),
        .redirect          (bco_valid),
        .perf_commit_cnt   (perf_commit_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );
`endif
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: randomized instruction-level checks of commit_ctrl against per-op timing expectations.
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;
    localparam int FH = 2;

    logic        clk = 0, resetn = 0;
    logic        rob_valid = 0, rob_ready = 0, rob_load = 0, rob_store = 0, rob_lsmiss = 0;
    logic        rob_bco_valid = 0, rob_bco_taken = 0;
    logic [31:0] rob_pc = 0, rob_value = 0, rob_bco_target = 0;
    logic [3:0]  rob_idx = 0, rob_cmtdelay = 0;
    logic [4:0]  rob_dst = 0;
    logic [7:0]  rob_fid = 0;
    logic [1:0]  rob_lswidth = 0, rob_bco_pattern = 0;
    logic        sb_cmt_ack = 0, lsr_done = 0;
    logic [31:0] lsr_data = 0;
    logic        rob_en_commit, rf_wen, sb_cmt_req, lsr_req, bco_valid, bco_taken;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, lsr_addr, bco_target, bco_pc;
    logic [3:0]  rf_wrob;
    logic [7:0]  sb_cmt_fid;
    logic [1:0]  lsr_width, bco_pattern;
`ifdef COMMIT_PERF_COUNTERS_EN
    logic [31:0] perf_commit_cnt, perf_redirect_cnt;
`endif

    commit_ctrl #(.FLUSH_HOLD(FH)) dut (
        .clk(clk), .resetn(resetn),
        .rob_valid(rob_valid), .rob_ready(rob_ready), .rob_load(rob_load), .rob_store(rob_store),
        .rob_lsmiss(rob_lsmiss), .rob_bco_valid(rob_bco_valid), .rob_bco_taken(rob_bco_taken),
        .rob_pc(rob_pc), .rob_value(rob_value), .rob_bco_target(rob_bco_target),
        .rob_idx(rob_idx), .rob_dst(rob_dst), .rob_fid(rob_fid), .rob_lswidth(rob_lswidth),
        .rob_bco_pattern(rob_bco_pattern), .rob_cmtdelay(rob_cmtdelay),
        .rob_en_commit(rob_en_commit), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wrob(rf_wrob), .sb_cmt_req(sb_cmt_req), .sb_cmt_fid(sb_cmt_fid), .sb_cmt_ack(sb_cmt_ack),
        .lsr_req(lsr_req), .lsr_addr(lsr_addr), .lsr_width(lsr_width), .lsr_done(lsr_done),
        .lsr_data(lsr_data),
`ifdef COMMIT_PERF_COUNTERS_EN
        .perf_commit_cnt(perf_commit_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
        .bco_valid(bco_valid), .bco_target(bco_target), .bco_pc(bco_pc),
        .bco_pattern(bco_pattern), .bco_taken(bco_taken)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] pc, value, target;
        logic [4:0]  dst;
        logic [3:0]  idx;
        logic [7:0]  fid;
        logic [1:0]  lsw, pat;
        logic        taken;
    } ent_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc = $urandom; e.value = $urandom; e.target = $urandom;
        e.dst = 5'($urandom_range(0, 31)); e.idx = 4'($urandom_range(0, 15));
        e.fid = 8'($urandom_range(0, 255)); e.lsw = 2'($urandom_range(0, 2));
        e.pat = 2'($urandom_range(0, 3)); e.taken = 1'($urandom_range(0, 1));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ent_t e, input logic st, input logic ld, input logic ms,
                         input logic bc, input logic [3:0] dly, input logic rdy);
        rob_valid = 1; rob_ready = rdy; rob_store = st; rob_load = ld; rob_lsmiss = ms;
        rob_bco_valid = bc; rob_cmtdelay = dly;
        rob_pc = e.pc; rob_value = e.value; rob_bco_target = e.target; rob_dst = e.dst;
        rob_idx = e.idx; rob_fid = e.fid; rob_lswidth = e.lsw; rob_bco_pattern = e.pat;
        rob_bco_taken = e.taken;
        #1;
    endtask

    task automatic check_rf(input logic [4:0] dst, input logic [31:0] data, input logic [3:0] idx);
        check("rf_wen", rf_wen, 32'(dst != 0));
        if (dst != 0) begin
            check("rf_waddr", rf_waddr, dst);
            check("rf_wdata", rf_wdata, data);
            check("rf_wrob", rf_wrob, idx);
        end
    endtask

    task automatic do_plain(input ent_t e, input int dly);
        drive(e, 0, 1'($urandom_range(0, 1)), 0, 0, 4'(dly), 1);
        for (int i = dly; i > 0; i--) begin
            check("delay_stall", rob_en_commit, 0);
            tick();
            rob_cmtdelay = 4'(i - 1);
            #1;
        end
        check("plain_commit", rob_en_commit, 1);
        tick();
        check_rf(e.dst, e.value, e.idx);
    endtask

    task automatic do_store(input ent_t e, input int k);
        drive(e, 1, 0, 0, 0, 0, 1);
        check("store_no_early_commit", rob_en_commit, 0);
        tick();
        for (int i = 1; i <= k; i++) begin
            sb_cmt_ack = (i == k);
            #1;
            check("sb_req_held", sb_cmt_req, 1);
            check("sb_fid", sb_cmt_fid, e.fid);
            check("store_commit", rob_en_commit, 32'(i == k));
            tick();
        end
        sb_cmt_ack = 0;
        check("sb_req_drop", sb_cmt_req, 0);
        check("store_no_rf", rf_wen, 0);
    endtask

    task automatic do_miss(input ent_t e, input int k, input logic [31:0] data);
        drive(e, 0, 1, 1, 0, 0, 1);
        check("miss_no_early_commit", rob_en_commit, 0);
        tick();
        check("lsr_req", lsr_req, 1);
        check("lsr_addr", lsr_addr, e.value);
        check("lsr_width", lsr_width, e.lsw);
        for (int i = 1; i <= k; i++) begin
            lsr_done = (i == k);
            lsr_data = (i == k) ? data : $urandom;
            #1;
            check("miss_commit", rob_en_commit, 32'(i == k));
            if (i > 1) check("lsr_req_pulse", lsr_req, 0);
            tick();
        end
        lsr_done = 0;
        check_rf(e.dst, data, e.idx);
    endtask

    task automatic do_bco(input ent_t e);
        drive(e, 0, 0, 0, 1, 0, 1);
        check("bco_commit", rob_en_commit, 1);
        tick();
        check("bco_valid", bco_valid, 1);
        check("bco_target", bco_target, e.target);
        check("bco_pc", bco_pc, e.pc);
        check("bco_pattern", bco_pattern, e.pat);
        check("bco_taken", bco_taken, e.taken);
        check_rf(e.dst, e.value, e.idx);
        drive(rnd_ent(), 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= FH; i++) begin
            check("flush_block", rob_en_commit, 0);
            if (i > 1) check("bco_pulse", bco_valid, 0);
            tick();
        end
    endtask

    task automatic do_idle();
        rob_valid = 0; rob_ready = 1;
        lsr_done = 1'($urandom_range(0, 1)); sb_cmt_ack = 1'($urandom_range(0, 1));
        #1;
        check("idle_no_commit", rob_en_commit, 0);
        tick();
        lsr_done = 0; sb_cmt_ack = 0;
    endtask

    initial begin
        ent_t e;
        tick(); tick();
        check("rst_commit", rob_en_commit, 0);
        check("rst_rf_wen", rf_wen, 0);
        check("rst_sb_req", sb_cmt_req, 0);
        check("rst_lsr_req", lsr_req, 0);
        check("rst_bco_valid", bco_valid, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_bco_target", bco_target, 0);
        resetn = 1;
        tick();
        e = rnd_ent(); e.dst = 3; do_plain(e, 0);
        e = rnd_ent(); e.dst = 0; do_plain(e, 0);
        e = rnd_ent(); e.dst = 7; do_plain(e, 0);
        e = rnd_ent(); e.dst = 9; do_store(e, 4);
        e = rnd_ent(); e.value = 32'h1000_0040; e.lsw = LSW_WORD; e.dst = 12;
        do_miss(e, 6, 32'hDEAD_BEEF);
        e = rnd_ent(); e.target = 32'h0000_2000; e.dst = 4; do_bco(e);
        e = rnd_ent(); e.dst = 5; do_plain(e, 3);
        drive(rnd_ent(), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("not_ready_stall", rob_en_commit, 0);
            tick();
        end
        e = rnd_ent(); e.dst = 6;
        drive(e, 0, 1, 1, 0, 0, 1);
        tick(); tick();
        resetn = 0;
        tick();
        check("rst_mid_lsr_req", lsr_req, 0);
        check("rst_mid_rf_wen", rf_wen, 0);
        resetn = 1; rob_valid = 0; lsr_done = 1; lsr_data = 32'hBAD0_BAD0;
        #1;
        check("rst_abandon_commit", rob_en_commit, 0);
        tick();
        lsr_done = 0;
        check("rst_abandon_rf", rf_wen, 0);
        check("rst_abandon_lsr", lsr_req, 0);
        e = rnd_ent(); do_plain(e, 0);
        do_idle();
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_plain(rnd_ent(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0);
                2: do_store(rnd_ent(), $urandom_range(1, 5));
                3: do_miss(rnd_ent(), $urandom_range(1, 6), $urandom);
                4: do_bco(rnd_ent());
                default: do_idle();
            endcase
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
